// File: rtl/i2c_audio_pkg.sv
// Shared types and constants for the codec I2C message engine.
package i2c_audio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_ACK,
    ST_STOP,
    ST_DONE
  } state_t;

  localparam int unsigned NUM_BYTES        = 3;
  localparam int unsigned BITS_PER_BYTE    = 8;
  localparam int unsigned MSG_W            = NUM_BYTES * BITS_PER_BYTE;
  localparam int unsigned QUARTERS_PER_MSG = 116;

  // Field positions inside i2c_data
  localparam int unsigned ADDR_HI  = 23;
  localparam int unsigned ADDR_LO  = 16;
  localparam int unsigned BYTE1_HI = 15;
  localparam int unsigned BYTE1_LO = 8;
  localparam int unsigned BYTE2_HI = 7;
  localparam int unsigned BYTE2_LO = 0;

  // Extract byte idx (0 = address, 1, 2) of a message word
  function automatic logic [7:0] msg_byte(input logic [23:0] d, input int unsigned idx);
    logic [7:0] b;
    case (idx)
      0:       b = d[ADDR_HI:ADDR_LO];
      1:       b = d[BYTE1_HI:BYTE1_LO];
      default: b = d[BYTE2_HI:BYTE2_LO];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/i2c_msg_master_if.sv
// Sequencer-side handshake between the configuration sequencer and the I2C engine.
interface i2c_msg_master_if;

  logic        msg_go;
  logic [23:0] i2c_data;
  logic        msg_end;
  logic        msg_ack;
  logic        busy;
  logic        sclk_tick;

  // Sequencer side
  modport master (
    output msg_go, i2c_data,
    input  msg_end, msg_ack, busy, sclk_tick
  );

  // Engine side
  modport slave (
    input  msg_go, i2c_data,
    output msg_end, msg_ack, busy, sclk_tick
  );

endinterface

// File: rtl/i2c_clk_div.sv
// Free-running quarter-SCL divider: one-cycle strobe every QDIV clocks.
module i2c_clk_div #(
  parameter int unsigned QDIV = 125
) (
  input  logic clk,
  input  logic reset,
  output logic sclk_tick
);

  localparam int unsigned CW = (QDIV > 1) ? $clog2(QDIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Count 0..QDIV-1 and emit a registered strobe on wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == CW'(QDIV - 1)) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign sclk_tick = r_tick;

endmodule

// File: rtl/i2c_msg_master.sv
// Bit-level I2C write engine: START, 3 bytes with ack slots, STOP per request.
module i2c_msg_master #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned I2C_HZ = 100_000,
  parameter int unsigned QDIV   = CLK_HZ / (4 * I2C_HZ)
) (
  input  logic            clk,
  input  logic            reset,
  i2c_msg_master_if.slave bus,
  output logic            i2c_sclk,
  inout  wire             i2c_sdat
);

  import i2c_audio_pkg::*;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_q, w_q_nxt;
  logic [2:0]       r_bit, w_bit_nxt;
  logic [1:0]       r_byte, w_byte_nxt;
  logic [MSG_W-1:0] r_shift, w_shift_nxt;
  logic             r_wait, w_wait_nxt;
  logic             r_nack, w_nack_nxt;
  logic             r_ackbit, w_ackbit_nxt;
  logic             r_end, w_end_nxt;
  logic             r_ack, w_ack_nxt;
  logic             r_busy, w_busy_nxt;

  logic             w_tick;
  logic             w_scl;
  logic             w_sda_low;
  logic             w_sda_in;

  i2c_clk_div #(.QDIV(QDIV)) u_clk_div (
    .clk      (clk),
    .reset    (reset),
    .sclk_tick(w_tick)
  );

  assign w_sda_in = i2c_sdat;

  // State, counters and status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_q      <= '0;
      r_bit    <= '0;
      r_byte   <= '0;
      r_shift  <= '0;
      r_wait   <= 1'b0;
      r_nack   <= 1'b0;
      r_ackbit <= 1'b0;
      r_end    <= 1'b0;
      r_ack    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_q      <= w_q_nxt;
      r_bit    <= w_bit_nxt;
      r_byte   <= w_byte_nxt;
      r_shift  <= w_shift_nxt;
      r_wait   <= w_wait_nxt;
      r_nack   <= w_nack_nxt;
      r_ackbit <= w_ackbit_nxt;
      r_end    <= w_end_nxt;
      r_ack    <= w_ack_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  // Next-state, counter updates and bus pin levels
  always_comb begin
    w_state_nxt  = r_state;
    w_q_nxt      = r_q;
    w_bit_nxt    = r_bit;
    w_byte_nxt   = r_byte;
    w_shift_nxt  = r_shift;
    w_wait_nxt   = r_wait;
    w_nack_nxt   = r_nack;
    w_ackbit_nxt = r_ackbit;
    w_end_nxt    = 1'b0;
    w_ack_nxt    = r_ack;
    w_busy_nxt   = r_busy;
    w_scl        = 1'b1;
    w_sda_low    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.msg_go) begin
          w_shift_nxt = bus.i2c_data;
          w_ack_nxt   = 1'b0;
          w_nack_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
          w_q_nxt     = '0;
          w_bit_nxt   = '0;
          w_byte_nxt  = '0;
          w_wait_nxt  = 1'b1;
          w_state_nxt = ST_START;
        end
      end

      ST_START: begin
        w_sda_low = r_q[1];
        // The first tick after acceptance only opens q0; quarters count from there
        if (w_tick) begin
          if (r_wait) begin
            w_wait_nxt = 1'b0;
          end else begin
            w_q_nxt = r_q + 2'd1;
            if (r_q == 2'd3) w_state_nxt = ST_BIT;
          end
        end
      end

      ST_BIT: begin
        w_scl     = r_q[1];
        w_sda_low = ~r_shift[MSG_W-1];
        if (w_tick) begin
          w_q_nxt = r_q + 2'd1;
          if (r_q == 2'd3) begin
            w_shift_nxt = {r_shift[MSG_W-2:0], 1'b0};
            w_bit_nxt   = r_bit + 3'd1;
            if (r_bit == 3'(BITS_PER_BYTE - 1)) w_state_nxt = ST_ACK;
          end
        end
      end

      ST_ACK: begin
        w_scl = r_q[1];
        if (w_tick) begin
          w_q_nxt = r_q + 2'd1;
          if (r_q == 2'd2) w_ackbit_nxt = w_sda_in;
          if (r_q == 2'd3) begin
            if (r_ackbit) begin
              w_nack_nxt  = 1'b1;
              w_state_nxt = ST_STOP;
            end else if (r_byte == 2'(NUM_BYTES - 1)) begin
              w_state_nxt = ST_STOP;
            end else begin
              w_byte_nxt  = r_byte + 2'd1;
              w_state_nxt = ST_BIT;
            end
          end
        end
      end

      ST_STOP: begin
        w_scl     = (r_q != 2'd0);
        w_sda_low = ~r_q[1];
        if (w_tick) begin
          w_q_nxt = r_q + 2'd1;
          if (r_q == 2'd3) begin
            w_end_nxt   = 1'b1;
            w_ack_nxt   = ~r_nack;
            w_state_nxt = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (!bus.msg_go) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign i2c_sclk      = w_scl;
  assign i2c_sdat      = w_sda_low ? 1'b0 : 1'bz;
  assign bus.msg_end   = r_end;
  assign bus.msg_ack   = r_ack;
  assign bus.busy      = r_busy;
  assign bus.sclk_tick = w_tick;

endmodule

// File: tb/tb_i2c_msg_master.sv
// Scoreboard bench for i2c_msg_master: I2C bus decoder + ack/nack slave model.
module tb_i2c_msg_master;

  import i2c_audio_pkg::*;

  localparam int unsigned TB_QDIV = 4;

  typedef struct {
    logic [23:0] data;
    int unsigned nb;
    logic        ack;
    int unsigned dur;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic w_scl;
  logic slave_drv;
  logic [2:0] nack_mask;
  wire  sda;

  int n_chk = 0;
  int n_fail = 0;
  int n_end = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  i2c_msg_master_if bus ();

  pullup pu_sda (sda);
  assign sda = slave_drv ? 1'b0 : 1'bz;

  i2c_msg_master #(.QDIV(TB_QDIV)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .i2c_sclk(w_scl),
    .i2c_sdat(sda)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Expected outcome: bytes up to and including the first nacked one
  task automatic push_exp(input logic [23:0] d, input logic [2:0] mask);
    exp_t e;
    int unsigned quarters;
    e.data = d;
    e.ack  = (mask == 3'b000);
    e.nb   = mask[0] ? 1 : (mask[1] ? 2 : 3);
    quarters = 4 + e.nb * 36 + 4;
    e.dur  = (quarters - 2) * TB_QDIV;
    exp_q.push_back(e);
  endtask

  task automatic start_msg(input logic [23:0] d, input logic [2:0] mask, input logic drop);
    @(negedge clk);
    bus.i2c_data = d;
    nack_mask    = mask;
    push_exp(d, mask);
    bus.msg_go   = 1'b1;
    @(posedge clk);
    #1;
    check("busy_rise", 32'(bus.busy), 32'd1);
    check("ack_clear_at_start", 32'(bus.msg_ack), 32'd0);
    if (drop) begin
      @(negedge clk);
      bus.msg_go = 1'b0;
    end
  endtask

  task automatic wait_end(input int prev, input int budget);
    int k = 0;
    while (n_end == prev && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("msg_end_within_budget", 32'(n_end > prev), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (bus.busy && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("return_idle", 32'(bus.busy), 32'd0);
  endtask

  // Monitor: decode the bus, act as slave, and score each msg_end
  initial begin : monitor
    logic        scl_s, sda_s, p_scl, p_sda, in_msg, stop_seen;
    int unsigned bitpos, nb, cyc, start_cyc;
    logic [7:0]  sr;
    logic [7:0]  obs [3];
    exp_t        e;
    p_scl = 1'b1; p_sda = 1'b1; in_msg = 1'b0; stop_seen = 1'b0;
    bitpos = 0; nb = 0; cyc = 0; start_cyc = 0; sr = '0;
    slave_drv = 1'b0;
    for (int i = 0; i < 3; i++) obs[i] = '0;
    forever begin
      @(negedge clk);
      cyc++;
      scl_s = w_scl;
      sda_s = sda;
      if (reset) begin
        in_msg    = 1'b0;
        bitpos    = 0;
        slave_drv = 1'b0;
      end else begin
        if (scl_s && p_scl && p_sda && !sda_s) begin
          in_msg = 1'b1; bitpos = 0; nb = 0; sr = '0; start_cyc = cyc;
          for (int i = 0; i < 3; i++) obs[i] = '0;
        end else if (scl_s && p_scl && !p_sda && sda_s) begin
          in_msg = 1'b0; bitpos = 0; stop_seen = 1'b1;
        end else if (in_msg && scl_s && !p_scl) begin
          if (bitpos < 8) begin
            sr = {sr[6:0], sda_s};
            bitpos++;
          end else begin
            if (nb < 3) obs[nb] = sr;
            nb++;
            bitpos = 0;
          end
        end else if (in_msg && !scl_s && p_scl) begin
          slave_drv = (bitpos == 8) && (nb < 3) && !nack_mask[nb < 3 ? nb : 0];
        end
        if (bus.msg_end) begin
          n_end++;
          if (exp_q.size() == 0) begin
            check("unexpected_msg_end", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("msg_ack", 32'(bus.msg_ack), 32'(e.ack));
            check("msg_len_clocks", cyc - start_cyc, e.dur);
            check("stop_seen", 32'(stop_seen), 32'd1);
            check("byte_count", nb, e.nb);
            for (int i = 0; i < 3; i++)
              if (32'(i) < e.nb) check($sformatf("byte%0d", i), 32'(obs[i]), 32'(msg_byte(e.data, i)));
          end
          stop_seen = 1'b0;
        end
      end
      p_scl = scl_s;
      p_sda = sda_s;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int ticks;
    int e0;
    reset        = 1'b1;
    bus.msg_go   = 1'b0;
    bus.i2c_data = '0;
    nack_mask    = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_msg_end", 32'(bus.msg_end), 32'd0);
    check("rst_msg_ack", 32'(bus.msg_ack), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_sclk", 32'(w_scl), 32'd1);
    check("rst_sda", 32'(sda), 32'd1);
    check("rst_tick", 32'(bus.sclk_tick), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    ticks = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.sclk_tick) ticks++;
    end
    check("tick_rate", ticks, 32'd10);

    // Full message, all acked
    e0 = n_end; start_msg(24'h34_1E_00, 3'b000, 1'b1); wait_end(e0, 1000); wait_idle(20);
    // Nack on address byte
    e0 = n_end; start_msg(24'h34_1E_00, 3'b001, 1'b1); wait_end(e0, 1000); wait_idle(20);
    // Nack on last byte only
    e0 = n_end; start_msg(24'h34_A5_5A, 3'b100, 1'b1); wait_end(e0, 1000); wait_idle(20);

    // msg_go held across msg_end: stays in DONE
    e0 = n_end; start_msg(24'h34_02_15, 3'b000, 1'b0); wait_end(e0, 1000);
    repeat (20) @(posedge clk);
    #1;
    check("hold_busy", 32'(bus.busy), 32'd1);
    check("hold_ack", 32'(bus.msg_ack), 32'd1);
    @(negedge clk);
    bus.msg_go = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("drop_go_idle", 32'(bus.busy), 32'd0);
    check("ack_kept_in_idle", 32'(bus.msg_ack), 32'd1);
    e0 = n_end; start_msg(24'h34_0C_00, 3'b000, 1'b1); wait_end(e0, 1000); wait_idle(20);

    // Data change and msg_go pulse mid-message are ignored
    e0 = n_end; start_msg(24'h34_5A_C3, 3'b000, 1'b1);
    repeat (150) @(posedge clk);
    @(negedge clk);
    bus.i2c_data = 24'hFF_FF_FF;
    bus.msg_go   = 1'b1;
    @(negedge clk);
    bus.msg_go   = 1'b0;
    wait_end(e0, 1000); wait_idle(20);

    // Reset during byte 1 data bits: bus released, no msg_end
    @(negedge clk);
    bus.i2c_data = 24'h34_77_11;
    nack_mask    = 3'b000;
    bus.msg_go   = 1'b1;
    @(negedge clk);
    bus.msg_go   = 1'b0;
    repeat (200) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_sclk", 32'(w_scl), 32'd1);
    check("midrst_sda", 32'(sda), 32'd1);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_msg_end", 32'(bus.msg_end), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    e0 = n_end; start_msg(24'h34_1E_00, 3'b000, 1'b1); wait_end(e0, 1000); wait_idle(20);

    repeat (10) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_msg_master.md
# i2c_msg_master

Bit-level I2C write engine that executes one 3-byte message (device address + 2 data bytes) per request from the audio codec configuration sequencer. It latches `i2c_data` on `msg_go`, generates START, 24 data bits with three acknowledge slots, and STOP on the codec's two-wire bus. It reports completion and acknowledge status back through `msg_end` and `msg_ack`. It sits between the configuration sequencer and the board's I2C pins, and is the only driver of the codec bus.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency.
- `I2C_HZ`, 100_000: SCL frequency.
- `QDIV`, CLK_HZ/(4*I2C_HZ) (=125): system clocks per quarter SCL period; must be ≥2.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `msg_go`  in  1  request level; a message starts when high in IDLE.
- `i2c_data`  in  24  message bits; [23:16] address+R/W, [15:8] byte 1, [7:0] byte 2; sent MSB first.
- `msg_end`  out  1  one-cycle pulse when the message (or abort) completes.
- `msg_ack`  out  1  1 = all three ack slots sampled low; valid from the `msg_end` cycle until the next start.
- `busy`  out  1  high from start acceptance until return to IDLE.
- `sclk_tick`  out  1  free-running one-cycle strobe every QDIV clocks; pacing enable for the sequencer.
- `i2c_sclk`  out  1  SCL, push-pull, idle high.
- `i2c_sdat`  inout  1  SDA, open-drain: drives 0 or high-Z, never 1.

## Operation
- States: IDLE, START, BIT, ACK, STOP, DONE.
- IDLE: SCL=1, SDA released. If `msg_go`=1, latch `i2c_data` into a shift register, clear `msg_ack`, assert `busy`, enter START.
- Every state advances one quarter per `sclk_tick`; a 2-bit quarter counter q0..q3 is held in each state.
- START: q0–q1 SDA released, SCL=1; q2–q3 SDA=0, SCL=1 (falling SDA while SCL high).
- BIT: q0 SCL=0 and SDA set to the current bit (0 → drive low, 1 → release); q1 SCL=0; q2–q3 SCL=1. After q3, the bit counter increments. After 8 bits, go to ACK.
- ACK: SDA released; SCL follows the BIT pattern. SDA is sampled at the end of q2. Low = ack.
  - On ack with byte counter < 2: increment byte counter, go to BIT.
  - On ack after byte 2: go to STOP.
  - On nack: record nack, go to STOP immediately (abort).
- STOP: q0 SCL=0, SDA=0; q1 SCL=1, SDA=0; q2–q3 SCL=1, SDA released.
- DONE: pulse `msg_end` for one cycle with `msg_ack` = no-nack-seen. Then hold (still `busy`) until `msg_go`=0, then go to IDLE. `msg_go` must drop between messages.
- `msg_go` and `i2c_data` are ignored outside IDLE; the latched copy is used for the whole message.

## Timing
- Reset values: `msg_end`=0, `msg_ack`=0, `busy`=0, `i2c_sclk`=1, SDA released, state IDLE, all counters 0, `sclk_tick`=0, divider cleared.
- Reset mid-message releases the bus immediately. No STOP is generated; the sequencer re-issues the message.
- Start latency: `busy` rises the cycle after `msg_go` is sampled high in IDLE. START begins on the next `sclk_tick`.
- Full message: 4 (START) + 27×4 (24 bits + 3 acks) + 4 (STOP) = 116 quarters. `msg_end` is asserted on the first clock after the tick that ends STOP q3.
- Nack on byte n (0..2): 4 + (n+1)×36 + 4 quarters.
- `sclk_tick` runs continuously, including in IDLE and DONE, and is unaffected by `msg_go`.
- Bit counter is 3 bits and wraps 7→0 into ACK. Byte counter is 2 bits, range 0..2.

## Structure
- Package `i2c_audio_pkg`: state enum; `NUM_BYTES`=3; `BITS_PER_BYTE`=8; `QUARTERS_PER_MSG`=116; message field slices of `i2c_data`.
- Sub-module `i2c_clk_div`: counter 0..QDIV-1 with async reset, producing `sclk_tick`.
- The FSM, shift register and counters live in `i2c_msg_master`.

## Test plan
- `i2c_data`=24'h34_1E_00, bench slave acks all slots, QDIV=4: exact START/24 bits/STOP waveform; `msg_end` after 116×4 clocks; `msg_ack`=1; decoded bytes 34,1E,00.
- Slave nacks address byte: STOP follows the first ACK slot; `msg_end` at 44 quarters; `msg_ack`=0; no byte 1 clocked.
- Nack on byte 2 only: full length (116 quarters), `msg_ack`=0.
- `msg_go` held high across `msg_end`: block stays in DONE with `busy`=1. Drop `msg_go`: IDLE. Raise `msg_go` with new data 24'h34_0C_00: second message uses the new data.
- Change `i2c_data` and pulse `msg_go` mid-message: transmitted bits unchanged, no restart.
- Assert `reset` during byte 1: next clock `i2c_sclk`=1, SDA high-Z, `busy`=0, `msg_end` never pulses; the next `msg_go` runs a clean full message.
